// File: rtl/lsu_ctrl_if.sv
`default_nettype none
// ======================================================================
// lsu_ctrl_if: request / memory / response bundle; master = LSU side
// Rev 1.0
// ======================================================================
interface lsu_ctrl_if #(
  parameter int ADDR_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_is_store;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ren;
  logic              mem_wen;
  logic [63:0]       mem_wdata;
  logic [7:0]        mem_wmask;
  logic [63:0]       mem_rdata;

  logic              resp_valid;
  logic              resp_ready;
  logic [63:0]       resp_rdata;
  logic              resp_err;

  modport master (
    input  req_valid, req_is_store, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_rdata, resp_ready,
    output req_ready, mem_addr, mem_ren, mem_wen, mem_wdata, mem_wmask,
    output resp_valid, resp_rdata, resp_err
  );

  modport slave (
    output req_valid, req_is_store, req_size, req_unsigned, req_addr, req_wdata,
    output mem_rdata, resp_ready,
    input  req_ready, mem_addr, mem_ren, mem_wen, mem_wdata, mem_wmask,
    input  resp_valid, resp_rdata, resp_err
  );
endinterface
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ======================================================================
// lsu_ctrl: load/store initiator with alignment check and lane steering
// Rev 1.0
// ======================================================================
module lsu_ctrl #(
  parameter int ADDR_W     = 64,
  parameter int RD_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst,
  lsu_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [2:0] C_RD_LAT = 3'(RD_LATENCY);

  state_t            state_q, state_d;
  logic [2:0]        off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              store_q, store_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_ren_q, mem_ren_d;
  logic              mem_wen_q, mem_wen_d;
  logic [63:0]       mem_wdata_q, mem_wdata_d;
  logic [7:0]        mem_wmask_q, mem_wmask_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [63:0]       resp_rdata_q, resp_rdata_d;

  logic [2:0]        w_off;
  logic              w_misaligned;
  logic [7:0]        w_base_mask;

  function automatic logic [63:0] extract(input logic [63:0] raw, input logic [2:0] off,
                                          input logic [1:0] size, input logic uns);
    logic [63:0] s;
    s = raw >> {off, 3'b000};
    case (size)
      2'd0:    extract = uns ? {56'b0, s[7:0]}  : {{56{s[7]}},  s[7:0]};
      2'd1:    extract = uns ? {48'b0, s[15:0]} : {{48{s[15]}}, s[15:0]};
      2'd2:    extract = uns ? {32'b0, s[31:0]} : {{32{s[31]}}, s[31:0]};
      default: extract = s;
    endcase
  endfunction

  assign w_off        = bus.req_addr[2:0];
  assign w_misaligned = ((bus.req_size == 2'd1) && w_off[0]) ||
                        ((bus.req_size == 2'd2) && (w_off[1:0] != 2'b00)) ||
                        ((bus.req_size == 2'd3) && (w_off != 3'b000));

  always_comb begin
    case (bus.req_size)
      2'd0:    w_base_mask = 8'h01;
      2'd1:    w_base_mask = 8'h03;
      2'd2:    w_base_mask = 8'h0F;
      default: w_base_mask = 8'hFF;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    size_d       = size_q;
    uns_d        = uns_q;
    store_d      = store_q;
    cnt_d        = cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_ren_d    = mem_ren_q;
    mem_wen_d    = mem_wen_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wmask_d  = mem_wmask_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          off_d   = w_off;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          store_d = bus.req_is_store;
          if (w_misaligned) begin
            // Errors skip the memory entirely and respond on the next cycle
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 64'd0;
            state_d      = S_RESP;
          end else begin
            // Strobes are registered here so they are high for exactly the ISSUE cycle
            mem_addr_d = {bus.req_addr[ADDR_W-1:3], 3'b000};
            if (bus.req_is_store) begin
              mem_wen_d   = 1'b1;
              mem_wdata_d = bus.req_wdata << {w_off, 3'b000};
              mem_wmask_d = w_base_mask << w_off;
            end else begin
              mem_ren_d   = 1'b1;
              mem_wmask_d = 8'h00;
            end
            state_d = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        mem_ren_d   = 1'b0;
        mem_wen_d   = 1'b0;
        mem_wmask_d = 8'h00;
        if (store_q) begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = 64'd0;
          state_d      = S_RESP;
        end else begin
          cnt_d   = C_RD_LAT;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (cnt_q == 3'd1) begin
          cnt_d        = 3'd0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = extract(bus.mem_rdata, off_q, size_q, uns_q);
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      S_RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_rdata_d = 64'd0;
          state_d      = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      off_q        <= 3'd0;
      size_q       <= 2'd0;
      uns_q        <= 1'b0;
      store_q      <= 1'b0;
      cnt_q        <= 3'd0;
      mem_addr_q   <= '0;
      mem_ren_q    <= 1'b0;
      mem_wen_q    <= 1'b0;
      mem_wdata_q  <= 64'd0;
      mem_wmask_q  <= 8'h00;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 64'd0;
    end else begin
      state_q      <= state_d;
      off_q        <= off_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      store_q      <= store_d;
      cnt_q        <= cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_ren_q    <= mem_ren_d;
      mem_wen_q    <= mem_wen_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wmask_q  <= mem_wmask_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_ren    = mem_ren_q;
  assign bus.mem_wen    = mem_wen_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_wmask  = mem_wmask_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;

endmodule
`default_nettype wire
